au_rr_arbiter: RTL

Round-robin arbiter that shares one arithmetic-unit resource among 2**WIDTH requesters. It registers a winning requester index, expands it to a one-hot grant through an `AU_decode` instance, and holds the grant until the owner drops its request. An optional hold timeout forces release. The block sits in front of any shared AU datapath and drives its operand-select mux from `gnt` or `gnt_idx`.

---
 rtl/au_rr_arbiter_pkg.sv | 30 +++
 rtl/au_rr_arbiter_decode.sv | 22 ++
 rtl/au_rr_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/au_rr_arbiter_pkg.sv
// Shared types and the round-robin pick function for au_rr_arbiter.
package au_arb_pkg;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} au_arb_state_e;

    localparam int AU_ARB_MIN_W = 1;
    localparam int AU_ARB_MAX_W = 6;

    // Scans upward from ptr with wrap at 2**width; width is at most AU_ARB_MAX_W.
    function automatic logic [AU_ARB_MAX_W-1:0] rr_pick(
        input logic [(1<<AU_ARB_MAX_W)-1:0] req,
        input logic [AU_ARB_MAX_W-1:0]      ptr,
        input int                           width
    );
        logic [AU_ARB_MAX_W:0]   nmask;
        logic [AU_ARB_MAX_W-1:0] idx;
        logic                    found;
        nmask   = (AU_ARB_MAX_W+1)'((1 << width) - 1);
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < (1 << AU_ARB_MAX_W); i++) begin
            idx = (ptr + AU_ARB_MAX_W'(i)) & nmask[AU_ARB_MAX_W-1:0];
            if (!found && (i < (1 << width)) && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/au_rr_arbiter_decode.sv
// Binary index to one-hot expansion; ARCH 0 uses a shifter, others a per-bit compare.
module AU_decode #(
    parameter int WIDTH = 3,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0]      idx_i,
    output logic [(1<<WIDTH)-1:0] onehot_o
);

    localparam int N = 1 << WIDTH;

    generate
        if (ARCH == 0) begin : g_shift
            assign onehot_o = {{(N-1){1'b0}}, 1'b1} << idx_i;
        end else begin : g_cmp
            for (genvar i = 0; i < N; i++) begin : g_bit
                assign onehot_o[i] = (idx_i == WIDTH'(i));
            end
        end
    endgenerate

endmodule

// File: rtl/au_rr_arbiter.sv
// Round-robin arbiter holding each grant until the owner drops its request.
// Optional forced release after MAX_HOLD cycles when AU_ARB_TIMEOUT_EN is defined.
module au_rr_arbiter
    import au_arb_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int ARCH     = 0,
    parameter int MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [(1<<WIDTH)-1:0] req,
    output logic [(1<<WIDTH)-1:0] gnt,
    output logic [WIDTH-1:0]      gnt_idx,
    output logic                  gnt_vld,
    output logic                  timeout
);

    localparam int N = 1 << WIDTH;

    generate
        if (WIDTH < AU_ARB_MIN_W || WIDTH > AU_ARB_MAX_W) begin : g_bad_width
            $error("au_rr_arbiter: WIDTH out of range");
        end
        if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_hold
            $error("au_rr_arbiter: MAX_HOLD out of range");
        end
    endgenerate

    au_arb_state_e    state_q, state_d;
    logic [WIDTH-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] pick;
    logic [N-1:0]     dec;
    logic             release_req;

    assign pick        = WIDTH'(rr_pick((1<<AU_ARB_MAX_W)'(req), AU_ARB_MAX_W'(ptr_q), WIDTH));
    assign release_req = !req[idx_q];

`ifdef AU_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        to_q, to_d;
    logic        expire;

    assign expire = (cnt_q == 16'(MAX_HOLD - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
`ifdef AU_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
`ifdef AU_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
`ifdef AU_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    idx_d   = pick;
`ifdef AU_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                // A plain release takes priority, so a coincident expiry reports no timeout.
                if (release_req) begin
                    state_d = IDLE;
                    ptr_d   = idx_q + WIDTH'(1);
`ifdef AU_ARB_TIMEOUT_EN
                end else if (expire) begin
                    state_d = IDLE;
                    ptr_d   = idx_q + WIDTH'(1);
                    to_d    = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    AU_decode #(.WIDTH(WIDTH), .ARCH(ARCH)) u_decode (
        .idx_i    (idx_q),
        .onehot_o (dec)
    );

    always_comb begin
        gnt_vld = (state_q == GRANT);
        gnt     = dec & {N{gnt_vld}};
        gnt_idx = idx_q;
`ifdef AU_ARB_TIMEOUT_EN
        timeout = to_q;
`else
        timeout = 1'b0;
`endif
    end

endmodule
